// File: rtl/recv_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : recv_dbg_pkg
// Description : Shared definitions for the receive-path watchdog/probe block:
//               capture FSM state encoding, probe field offsets/widths inside
//               the 94-bit sample word, and the sample width itself.
// Revision    : 1.0 - initial release
// ============================================================================
package recv_dbg_pkg;

  // Capture FSM encoding
  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_BUSY  = 2'd2,
    CAP_DONE  = 2'd3
  } cap_state_t;

  // Width of one stored probe sample
  localparam int PROBE_W = 94;

  // Field layout of the sample word, probe0 in the least significant bits
  localparam int P0_LSB = 0;   localparam int P0_W = 8;   // ARP out byte
  localparam int P1_LSB = 8;   localparam int P1_W = 1;   // ARP out valid
  localparam int P2_LSB = 9;   localparam int P2_W = 1;   // ARP out last
  localparam int P3_LSB = 10;  localparam int P3_W = 1;   // input valid
  localparam int P4_LSB = 11;  localparam int P4_W = 3;   // parser state
  localparam int P5_LSB = 14;  localparam int P5_W = 16;  // byte counter
  localparam int P6_LSB = 30;  localparam int P6_W = 48;  // 6-byte window
  localparam int P7_LSB = 78;  localparam int P7_W = 16;  // 2-byte window

endpackage : recv_dbg_pkg
`default_nettype wire

// File: rtl/wd_timer.sv
`default_nettype none
// ============================================================================
// Module      : wd_timer
// Description : Free-wrapping watchdog counter. Counts enabled cycles and
//               emits a single-cycle timer_out pulse on the cycle after the
//               2^TIMER_WIDTH-th enabled cycle since the last reset.
// Ports       : clk       - system clock
//               reset     - synchronous active-high clear (count and pulse)
//               enable    - count on cycles where high
//               timer_out - one-cycle timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
module wd_timer #(
  parameter int TIMER_WIDTH = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic timer_out
);

  localparam logic [TIMER_WIDTH-1:0] c_CNT_MAX = '1;

  logic [TIMER_WIDTH-1:0] r_count;
  logic                   r_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else if (enable) begin
      // Terminal count wraps to zero and fires the pulse for one cycle
      r_count   <= (r_count == c_CNT_MAX) ? '0 : r_count + 1'b1;
      r_timeout <= (r_count == c_CNT_MAX);
    end else begin
      r_timeout <= 1'b0;
    end
  end

  assign timer_out = r_timeout;

endmodule : wd_timer
`default_nettype wire

// File: rtl/recv_watchdog_probe.sv
`default_nettype none
// ============================================================================
// Module      : recv_watchdog_probe
// Description : Receive-buffer support block. Holds the parser stall watchdog
//               and a post-trigger probe capture memory of CAP_DEPTH samples
//               with a synchronous one-cycle-latency readout port.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               timer_clear/enable  - watchdog clear and count enable
//               timer_out           - watchdog timeout pulse
//               probe0..probe7      - parser debug signals to record
//               cap_arm, cap_trig   - arm pulse and trigger qualifier
//               cap_armed/busy/done - capture status
//               rd_addr, rd_data    - sample readout (one-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module recv_watchdog_probe
  import recv_dbg_pkg::*;
#(
  parameter int TIMER_WIDTH = 12,
  parameter int CAP_DEPTH   = 64,
  parameter int CAP_AW      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              timer_clear,
  input  logic              timer_enable,
  output logic              timer_out,
  input  logic [7:0]        probe0,
  input  logic              probe1,
  input  logic              probe2,
  input  logic              probe3,
  input  logic [2:0]        probe4,
  input  logic [15:0]       probe5,
  input  logic [47:0]       probe6,
  input  logic [15:0]       probe7,
  input  logic              cap_arm,
  input  logic              cap_trig,
  output logic              cap_armed,
  output logic              cap_busy,
  output logic              cap_done,
  input  logic [CAP_AW-1:0] rd_addr,
  output logic [PROBE_W-1:0] rd_data
);

  localparam logic [CAP_AW-1:0] c_LAST_PTR = CAP_AW'(CAP_DEPTH - 1);

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  logic w_wd_reset;
  assign w_wd_reset = reset | timer_clear;

  wd_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_wd_timer (
    .clk       (clk),
    .reset     (w_wd_reset),
    .enable    (timer_enable),
    .timer_out (timer_out)
  );

  // --------------------------------------------------------------------------
  // Sample word assembly
  // --------------------------------------------------------------------------
  logic [PROBE_W-1:0] w_sample;

  always_comb begin
    w_sample                  = '0;
    w_sample[P0_LSB +: P0_W]  = probe0;
    w_sample[P1_LSB +: P1_W]  = probe1;
    w_sample[P2_LSB +: P2_W]  = probe2;
    w_sample[P3_LSB +: P3_W]  = probe3;
    w_sample[P4_LSB +: P4_W]  = probe4;
    w_sample[P5_LSB +: P5_W]  = probe5;
    w_sample[P6_LSB +: P6_W]  = probe6;
    w_sample[P7_LSB +: P7_W]  = probe7;
  end

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  cap_state_t        r_state;
  cap_state_t        w_state_next;
  logic [CAP_AW-1:0] r_wptr;
  logic [CAP_AW-1:0] w_wptr_next;
  logic              w_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CAP_IDLE;
      r_wptr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wptr  <= w_wptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wptr_next  = r_wptr;
    w_we         = 1'b0;
    cap_armed    = 1'b0;
    cap_busy     = 1'b0;
    cap_done     = 1'b0;
    case (r_state)
      CAP_IDLE: begin
        if (cap_arm) begin
          w_state_next = CAP_ARMED;
          w_wptr_next  = '0;
        end
      end
      CAP_ARMED: begin
        cap_armed = 1'b1;
        // A re-arm takes priority over a coincident trigger
        if (cap_arm) begin
          w_wptr_next = '0;
        end else if (cap_trig) begin
          w_we         = 1'b1;
          w_wptr_next  = r_wptr + 1'b1;
          w_state_next = CAP_BUSY;
        end
      end
      CAP_BUSY: begin
        cap_busy = 1'b1;
        if (cap_arm) begin
          // Restart; locations already written are left stale
          w_state_next = CAP_ARMED;
          w_wptr_next  = '0;
        end else begin
          w_we        = 1'b1;
          w_wptr_next = r_wptr + 1'b1;   // wraps to 0 after the last slot
          if (r_wptr == c_LAST_PTR) begin
            w_state_next = CAP_DONE;
          end
        end
      end
      CAP_DONE: begin
        cap_done = 1'b1;
        if (cap_arm) begin
          w_state_next = CAP_ARMED;
          w_wptr_next  = '0;
        end
      end
      default: begin
        w_state_next = CAP_IDLE;
        w_wptr_next  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture memory: contents are not reset, so the array sits in its own
  // process and maps onto a plain RAM. Read-during-write returns old data.
  // --------------------------------------------------------------------------
  logic [PROBE_W-1:0] r_mem [CAP_DEPTH];
  logic [PROBE_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wptr] <= w_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule : recv_watchdog_probe
`default_nettype wire

// File: tb/tb_recv_watchdog_probe.sv
`default_nettype none
// ============================================================================
// Module      : tb_recv_watchdog_probe
// Description : Directed self-checking bench for recv_watchdog_probe with a
//               4-bit watchdog and a 64-entry capture memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recv_watchdog_probe;

  localparam int TW = 4;
  localparam int DEPTH = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          timer_clear;
  logic          timer_enable;
  logic          timer_out;
  logic [7:0]    probe0;
  logic          probe1;
  logic          probe2;
  logic          probe3;
  logic [2:0]    probe4;
  logic [15:0]   probe5;
  logic [47:0]   probe6;
  logic [15:0]   probe7;
  logic          cap_arm;
  logic          cap_trig;
  logic          cap_armed;
  logic          cap_busy;
  logic          cap_done;
  logic [AW-1:0] rd_addr;
  logic [93:0]   rd_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] trig_val;
  logic [15:0] tv2;
  logic [15:0] v1;

  recv_watchdog_probe #(
    .TIMER_WIDTH (TW),
    .CAP_DEPTH   (DEPTH),
    .CAP_AW      (AW)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .timer_clear  (timer_clear),
    .timer_enable (timer_enable),
    .timer_out    (timer_out),
    .probe0       (probe0),
    .probe1       (probe1),
    .probe2       (probe2),
    .probe3       (probe3),
    .probe4       (probe4),
    .probe5       (probe5),
    .probe6       (probe6),
    .probe7       (probe7),
    .cap_arm      (cap_arm),
    .cap_trig     (cap_trig),
    .cap_armed    (cap_armed),
    .cap_busy     (cap_busy),
    .cap_done     (cap_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the edge and probe5
  // behaves as a free-running counter updated right after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    probe5 = probe5 + 16'd1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset        = 1'b1;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    probe0       = 8'h5A;
    probe1       = 1'b1;
    probe2       = 1'b0;
    probe3       = 1'b1;
    probe4       = 3'd5;
    probe5       = 16'h1230;
    probe6       = 48'h0;
    probe7       = 16'h0;
    cap_arm      = 1'b0;
    cap_trig     = 1'b0;
    rd_addr      = '0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    reset = 1'b0;
    check("rst_timer_out", 128'(timer_out), 128'd0);
    check("rst_armed",     128'(cap_armed), 128'd0);
    check("rst_busy",      128'(cap_busy),  128'd0);
    check("rst_done",      128'(cap_done),  128'd0);
    check("rst_rd_data",   128'(rd_data),   128'd0);

    // ---------------- watchdog, enable held high ----------------
    timer_clear = 1'b1;
    tick();
    timer_clear  = 1'b0;
    timer_enable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check($sformatf("wd_hold_%0d", i), 128'(timer_out),
            128'((i % 16) == 0));
    end

    // ---------------- watchdog, enable toggling ----------------
    timer_enable = 1'b0;
    timer_clear  = 1'b1;
    tick();
    timer_clear = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      timer_enable = (i % 2) == 1;
      tick();
      check($sformatf("wd_toggle_%0d", i), 128'(timer_out),
            128'(i == 31));
    end

    // Clear coincides with the 10th enabled cycle (i=19); the 16th
    // subsequent enabled cycle is i=51.
    timer_enable = 1'b0;
    timer_clear  = 1'b1;
    tick();
    timer_clear = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      timer_enable = (i % 2) == 1;
      timer_clear  = (i == 19);
      tick();
      check($sformatf("wd_clr_%0d", i), 128'(timer_out),
            128'(i == 51));
    end
    timer_enable = 1'b0;
    timer_clear  = 1'b0;

    // ---------------- full capture ----------------
    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    check("arm_armed", 128'(cap_armed), 128'd1);
    check("arm_busy",  128'(cap_busy),  128'd0);
    repeat (20) tick();
    check("wait_armed", 128'(cap_armed), 128'd1);
    check("wait_busy",  128'(cap_busy),  128'd0);

    cap_trig = 1'b1;
    probe6   = 48'hFFFF_FFFF_FFFF;
    probe7   = 16'h0806;
    trig_val = probe5;
    tick();
    cap_trig = 1'b0;
    probe6   = 48'h1234_5678_9ABC;
    probe7   = 16'h0000;
    check("trig_busy",  128'(cap_busy),  128'd1);
    check("trig_armed", 128'(cap_armed), 128'd0);
    for (int j = 1; j <= 63; j++) begin
      tick();
      if (j == 62) begin
        check("pre_done_busy", 128'(cap_busy), 128'd1);
        check("pre_done_done", 128'(cap_done), 128'd0);
      end
    end
    check("done_done", 128'(cap_done), 128'd1);
    check("done_busy", 128'(cap_busy), 128'd0);

    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = AW'(k);
      tick();
      check($sformatf("rd_p5_%0d", k), 128'(rd_data[29:14]),
            128'(trig_val + 16'(k)));
    end
    rd_addr = '0;
    tick();
    check("rd0_p7",    128'(rd_data[93:78]), 128'h0806);
    check("rd0_p6",    128'(rd_data[77:30]), 128'hFFFF_FFFF_FFFF);
    check("rd0_low",   128'(rd_data[13:0]),  128'(14'b101_1_0_1_01011010));
    rd_addr = AW'(1);
    tick();
    check("rd1_p7",    128'(rd_data[93:78]), 128'h0000);
    check("rd1_p6",    128'(rd_data[77:30]), 128'h1234_5678_9ABC);
    check("still_done", 128'(cap_done), 128'd1);

    // ---------------- read-during-write at address 1 ----------------
    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    check("rearm_armed", 128'(cap_armed), 128'd1);
    check("rearm_done",  128'(cap_done),  128'd0);
    cap_trig = 1'b1;
    rd_addr  = AW'(1);
    tick();                 // writes address 0
    cap_trig = 1'b0;
    v1 = probe5;
    tick();                 // writes address 1, reads old contents
    check("rdw_old", 128'(rd_data[29:14]), 128'(trig_val + 16'd1));
    tick();
    check("rdw_new", 128'(rd_data[29:14]), 128'(v1));

    // ---------------- re-arm during BUSY at pointer 30 ----------------
    repeat (27) tick();     // pointer now 30
    check("p30_busy", 128'(cap_busy), 128'd1);
    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    check("abort_armed", 128'(cap_armed), 128'd1);
    check("abort_busy",  128'(cap_busy),  128'd0);
    repeat (3) tick();
    check("abort_wait", 128'(cap_armed), 128'd1);
    cap_trig = 1'b1;
    probe7   = 16'hBEEF;
    tv2      = probe5;
    tick();
    cap_trig = 1'b0;
    probe7   = 16'h0000;
    check("retrig_busy", 128'(cap_busy), 128'd1);
    rd_addr = '0;
    tick();
    check("retrig_a0_p5", 128'(rd_data[29:14]), 128'(tv2));
    check("retrig_a0_p7", 128'(rd_data[93:78]), 128'hBEEF);
    rd_addr = AW'(31);
    tick();
    check("stale_a31", 128'(rd_data[29:14]), 128'(trig_val + 16'd31));

    // ---------------- reset mid-capture ----------------
    timer_enable = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    timer_enable = 1'b0;
    check("midrst_armed", 128'(cap_armed), 128'd0);
    check("midrst_busy",  128'(cap_busy),  128'd0);
    check("midrst_done",  128'(cap_done),  128'd0);
    check("midrst_tout",  128'(timer_out), 128'd0);
    check("midrst_rd",    128'(rd_data),   128'd0);
    repeat (3) tick();
    check("idle_busy", 128'(cap_busy), 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_recv_watchdog_probe
`default_nettype wire
